// File: rtl/mips_dump_sequencer.sv
// mips_dump_sequencer
//
// Streams a snapshot of MIPS state out through a byte-wide UART transmitter.
// The snapshot order is PC, cycle count, registers 0..CELDAS_REGISTROS-1 and,
// when DUMP_MEM_EN is defined, data-memory words 0..CELDAS_MEM_DATOS-1.
// Each word is sent least-significant byte first.
//
// Build option: define DUMP_MEM_EN to include data memory in the dump. When it
// is undefined, the dump ends after the last register, o_mips_mem is held at 0
// and i_mips_mem is ignored.
//
// Ports:
//   clk              single clock, rising edge
//   reset            synchronous, active-low reset
//   i_start          one-cycle dump request, honoured only while idle
//   i_mips_pc        current PC
//   i_mips_clk_count MIPS cycle count
//   i_mips_reg       register value addressed by o_mips_reg
//   i_mips_mem       memory word addressed by o_mips_mem
//   i_uart_tx_done   one-cycle pulse when the transmitter finishes a byte
//   o_mips_reg       register select
//   o_mips_mem       memory word select
//   o_uart_tx_data   byte to transmit
//   o_uart_tx_ready  one-cycle transmit-start pulse
//   o_busy           high while a dump is in progress
//   o_done           one-cycle pulse when a dump completes
module mips_dump_sequencer #(
  parameter int NBITS            = 32,
  parameter int DATA_BITS        = 8,
  parameter int CELDAS_REGISTROS = 32,
  parameter int CELDAS_MEM_DATOS = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_start,
  input  logic [NBITS-1:0]                    i_mips_pc,
  input  logic [NBITS-1:0]                    i_mips_clk_count,
  input  logic [NBITS-1:0]                    i_mips_reg,
  input  logic [NBITS-1:0]                    i_mips_mem,
  input  logic                                i_uart_tx_done,
  output logic [$clog2(CELDAS_REGISTROS)-1:0] o_mips_reg,
  output logic [NBITS-1:0]                    o_mips_mem,
  output logic [DATA_BITS-1:0]                o_uart_tx_data,
  output logic                                o_uart_tx_ready,
  output logic                                o_busy,
  output logic                                o_done
);

  localparam int REG_W  = $clog2(CELDAS_REGISTROS);
  localparam int BYTES  = NBITS / DATA_BITS;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
`ifdef DUMP_MEM_EN
  localparam int MEM_WORDS = CELDAS_MEM_DATOS;
`else
  localparam int MEM_WORDS = 0;
`endif
  localparam int TOTAL_WORDS = 2 + CELDAS_REGISTROS + MEM_WORDS;
  // One extra code so the index can hold TOTAL_WORDS after the final NEXT.
  localparam int IDX_W = $clog2(TOTAL_WORDS + 1);

  localparam logic [IDX_W-1:0]  REG_BASE  = IDX_W'(2);
  localparam logic [IDX_W-1:0]  MEM_BASE  = IDX_W'(2 + CELDAS_REGISTROS);
  localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(TOTAL_WORDS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SELECT = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] SEND   = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] NEXT   = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0]        state_q;
  logic [IDX_W-1:0]  word_idx_q;
  logic [BYTE_W-1:0] byte_idx_q;
  logic [NBITS-1:0]  shift_q;
  logic [REG_W-1:0]  reg_sel_q;

  logic              enter_select;
  logic [IDX_W-1:0]  sel_idx;
  logic [NBITS-1:0]  load_word;

  // Selects are registered on the way into SELECT so they are valid during
  // SELECT and stay put through LOAD, which suits both combinational and
  // registered read ports on the MIPS side.
  assign enter_select = ((state_q == IDLE) && i_start) ||
                        ((state_q == NEXT) && (word_idx_q != LAST_WORD));
  assign sel_idx      = (state_q == IDLE) ? '0 : word_idx_q + IDX_W'(1);

  always_comb begin
    load_word = i_mips_reg;
    if (word_idx_q == '0) begin
      load_word = i_mips_pc;
    end else if (word_idx_q == IDX_W'(1)) begin
      load_word = i_mips_clk_count;
`ifdef DUMP_MEM_EN
    end else if (word_idx_q >= MEM_BASE) begin
      load_word = i_mips_mem;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      reg_sel_q  <= '0;
    end else begin
      if (enter_select && (sel_idx >= REG_BASE) && (sel_idx < MEM_BASE)) begin
        reg_sel_q <= REG_W'(sel_idx - REG_BASE);
      end
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q    <= SELECT;
            word_idx_q <= '0;
          end
        end
        SELECT: state_q <= LOAD;
        LOAD: begin
          shift_q    <= load_word;
          byte_idx_q <= '0;
          state_q    <= SEND;
        end
        SEND: state_q <= WAIT;
        WAIT: begin
          // tx_done is only listened to here; pulses elsewhere are dropped.
          if (i_uart_tx_done) begin
            if (byte_idx_q != LAST_BYTE) begin
              shift_q    <= shift_q >> DATA_BITS;
              byte_idx_q <= byte_idx_q + BYTE_W'(1);
              state_q    <= SEND;
            end else begin
              state_q <= NEXT;
            end
          end
        end
        NEXT: begin
          word_idx_q <= word_idx_q + IDX_W'(1);
          state_q    <= (word_idx_q == LAST_WORD) ? DONE : SELECT;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DUMP_MEM_EN
  logic [NBITS-1:0] mem_sel_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_sel_q <= '0;
    end else if (enter_select && (sel_idx >= MEM_BASE)) begin
      mem_sel_q <= NBITS'(sel_idx - MEM_BASE);
    end
  end

  assign o_mips_mem = mem_sel_q;
`else
  logic unused_mem;

  assign o_mips_mem = '0;
  assign unused_mem = (^i_mips_mem) ^ (CELDAS_MEM_DATOS > 0);
`endif

  assign o_mips_reg      = reg_sel_q;
  assign o_uart_tx_data  = shift_q[DATA_BITS-1:0];
  assign o_uart_tx_ready = (state_q == SEND);
  assign o_busy          = (state_q != IDLE);
  assign o_done          = (state_q == DONE);

endmodule

// File: tb/tb_mips_dump_sequencer.sv
// Self-checking bench for mips_dump_sequencer at default parameters.
// The reference model is a byte stream built from the word list plus a small
// event timeline (ready/done due N cycles after the stimulus that causes it).
module tb_mips_dump_sequencer;

  localparam int NREG = 32;
  localparam int NMEM = 16;
`ifdef DUMP_MEM_EN
  localparam bit MEM_EN = 1'b1;
`else
  localparam bit MEM_EN = 1'b0;
`endif
  localparam int NWORDS = 2 + NREG + (MEM_EN ? NMEM : 0);
  localparam int NBYTES = NWORDS * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_uart_tx_done = 1'b0;
  logic [31:0] i_mips_pc = '0;
  logic [31:0] i_mips_clk_count = '0;
  logic [31:0] i_mips_reg;
  logic [31:0] i_mips_mem;
  logic [4:0]  o_mips_reg;
  logic [31:0] o_mips_mem;
  logic [7:0]  o_uart_tx_data;
  logic        o_uart_tx_ready;
  logic        o_busy;
  logic        o_done;

  mips_dump_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .i_start          (i_start),
    .i_mips_pc        (i_mips_pc),
    .i_mips_clk_count (i_mips_clk_count),
    .i_mips_reg       (i_mips_reg),
    .i_mips_mem       (i_mips_mem),
    .i_uart_tx_done   (i_uart_tx_done),
    .o_mips_reg       (o_mips_reg),
    .o_mips_mem       (o_mips_mem),
    .o_uart_tx_data   (o_uart_tx_data),
    .o_uart_tx_ready  (o_uart_tx_ready),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] n);
    return 32'h5EED_0000 ^ (n * 32'h0001_0203);
  endfunction

  // MIPS side: register n reads 0xA0000000+n, memory is a fixed pattern.
  assign i_mips_reg = 32'hA000_0000 + {27'd0, o_mips_reg};
  assign i_mips_mem = mem_word(o_mips_mem);

  int errors = 0;
  int checks = 0;

  // Model state
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int  sent;
  bit  busy_m;
  bit  waiting;
  int  dcnt;
  int  evt_kind;  // 0 none, 1 ready, 2 done
  int  evt_cnt;
  bit  zero_chk;
  int  done_seen;
  int  cyc;
  int  start_cyc;
  int  first_rdy_cyc;
  // Stimulus knobs
  int  fixed_delay;
  bit  spur_en;
  bit  bstart_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sched(input int kind, input int n);
    evt_kind = kind;
    evt_cnt  = n;
  endtask

  task automatic build_stream(input logic [31:0] pc, input logic [31:0] cnt);
    logic [31:0] w;
    exp_q.delete();
    for (int k = 0; k < NWORDS; k++) begin
      if (k == 0)             w = pc;
      else if (k == 1)        w = cnt;
      else if (k < 2 + NREG)  w = 32'hA000_0000 + 32'(k - 2);
      else                    w = mem_word(32'(k - 2 - NREG));
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  // One clock cycle: compare at the falling edge, then drive the inputs that
  // the next rising edge will sample, and advance the model.
  task automatic step(input bit want_start, input bit want_reset);
    bit rdy_e, done_e, drv_done, drv_start, cur_busy;
    int word;
    @(negedge clk);
    cyc++;
    rdy_e  = 1'b0;
    done_e = 1'b0;
    if (evt_kind != 0) begin
      evt_cnt--;
      if (evt_cnt == 0) begin
        rdy_e    = (evt_kind == 1);
        done_e   = (evt_kind == 2);
        evt_kind = 0;
      end
    end

    chk("busy", {31'd0, o_busy}, {31'd0, busy_m});
    chk("tx_ready", {31'd0, o_uart_tx_ready}, {31'd0, rdy_e});
    chk("done", {31'd0, o_done}, {31'd0, done_e});
    if (!MEM_EN) chk("mem_sel_held_zero", o_mips_mem, 32'd0);
    if (zero_chk) begin
      chk("reset_tx_data", {24'd0, o_uart_tx_data}, 32'd0);
      chk("reset_reg_sel", {27'd0, o_mips_reg}, 32'd0);
      chk("reset_mem_sel", o_mips_mem, 32'd0);
      zero_chk = 1'b0;
    end
    if (rdy_e) begin
      if (sent < exp_q.size()) chk("tx_data", {24'd0, o_uart_tx_data}, {24'd0, exp_q[sent]});
      else chk("tx_data_extra", {24'd0, o_uart_tx_data}, 32'hFFFF_FFFF);
      word = sent / 4;
      if (sent % 4 == 0 && word >= 2 && word < 2 + NREG)
        chk("reg_sel", {27'd0, o_mips_reg}, 32'(word - 2));
      if (MEM_EN && sent % 4 == 0 && word >= 2 + NREG)
        chk("mem_sel", o_mips_mem, 32'(word - 2 - NREG));
      if (sent == 0) first_rdy_cyc = cyc;
      got.push_back(o_uart_tx_data);
    end
    if (o_done) done_seen++;

    // tx_done: either the real completion of the byte in flight, or a stray
    // pulse at a time the sequencer must ignore it.
    drv_done = 1'b0;
    if (waiting) begin
      dcnt--;
      if (dcnt == 0) begin
        drv_done = 1'b1;
        waiting  = 1'b0;
        sent++;
        if (sent % 4 != 0)       sched(1, 1);
        else if (sent == NBYTES) sched(2, 2);
        else                     sched(1, 4);
      end
    end else if (spur_en && $urandom_range(2) == 0) begin
      drv_done = 1'b1;
    end
    if (rdy_e) begin
      waiting = 1'b1;
      dcnt    = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
    end

    cur_busy  = busy_m;
    drv_start = want_start || (bstart_en && cur_busy && $urandom_range(5) == 0);
    if (done_e) busy_m = 1'b0;
    if (drv_start && !cur_busy && !want_reset) begin
      busy_m    = 1'b1;
      sent      = 0;
      start_cyc = cyc;
      build_stream(i_mips_pc, i_mips_clk_count);
      sched(1, 3);
    end
    if (want_reset) begin
      busy_m   = 1'b0;
      waiting  = 1'b0;
      evt_kind = 0;
      zero_chk = 1'b1;
    end

    i_start        = drv_start;
    i_uart_tx_done = drv_done;
    reset          = ~want_reset;
  endtask

  task automatic run_dump(input logic [31:0] pc, input logic [31:0] cnt, input int delay,
                          input bit spur, input bit bstart, input int rst_byte);
    int budget;
    fixed_delay      = delay;
    spur_en          = spur;
    bstart_en        = bstart;
    i_mips_pc        = pc;
    i_mips_clk_count = cnt;
    got.delete();
    done_seen = 0;
    step(1'b1, 1'b0);
    budget = 0;
    while (busy_m && budget < 5000) begin
      step(1'b0, (rst_byte >= 0) && waiting && (sent == rst_byte));
      budget++;
    end
    if (budget >= 5000) begin
      errors++;
      checks++;
      $display("FAIL dump_timeout: still busy after %0d cycles, expected idle", budget);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] pc_r;
    cyc = 0; sent = 0; busy_m = 0; waiting = 0; dcnt = 0; evt_kind = 0; evt_cnt = 0;
    zero_chk = 0; done_seen = 0; start_cyc = 0; first_rdy_cyc = 0;
    fixed_delay = 2; spur_en = 0; bstart_en = 0;
    repeat (2) @(posedge clk);
    step(1'b0, 1'b1);   // reset held; outputs checked all-zero next cycle
    repeat (3) step(1'b0, 1'b0);

    // Full dump with PC 0x12345678, tx_done two cycles after each ready.
    run_dump(32'h1234_5678, $urandom, 2, 1'b0, 1'b0, -1);
    chk("full_byte_count", got.size(), NBYTES);
    chk("full_done_count", done_seen, 1);
    chk("start_to_ready_latency", first_rdy_cyc - start_cyc, 3);
    chk("pc_byte0", {24'd0, got[0]}, 32'h78);
    chk("pc_byte1", {24'd0, got[1]}, 32'h56);
    chk("pc_byte2", {24'd0, got[2]}, 32'h34);
    chk("pc_byte3", {24'd0, got[3]}, 32'h12);
    chk("reg0_byte0", {24'd0, got[8]}, 32'h00);
    chk("reg0_byte1", {24'd0, got[9]}, 32'h00);
    chk("reg0_byte2", {24'd0, got[10]}, 32'h00);
    chk("reg0_byte3", {24'd0, got[11]}, 32'hA0);
    chk("reg31_byte0", {24'd0, got[8 + 31*4]}, 32'h1F);
    chk("reg31_byte3", {24'd0, got[8 + NREG*4 - 1]}, 32'hA0);

    // Random delays, stray tx_done pulses (incl. in SEND) and start while busy.
    repeat (2) begin
      run_dump($urandom, $urandom, 0, 1'b1, 1'b1, -1);
      chk("rand_byte_count", got.size(), NBYTES);
      chk("rand_done_count", done_seen, 1);
    end

    // Reset while waiting on byte 5: abort, no done, then a clean restart.
    run_dump($urandom, $urandom, 0, 1'b0, 1'b0, 5);
    chk("abort_byte_count", got.size(), 6);
    chk("abort_done_count", done_seen, 0);
    repeat (3) step(1'b0, 1'b0);
    pc_r = $urandom;
    run_dump(pc_r, $urandom, 0, 1'b1, 1'b0, -1);
    chk("restart_first_byte", {24'd0, got[0]}, {24'd0, pc_r[7:0]});
    chk("restart_byte_count", got.size(), NBYTES);
    chk("restart_done_count", done_seen, 1);

    // Idle with stray tx_done pulses: nothing may start.
    spur_en = 1'b1;
    repeat (20) step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_dump_sequencer.md
MIPS_DUMP_SEQUENCER -- requirements
Module: mips_dump_sequencer

Interface
REQ-001 SHALL have parameter NBITS, default 32, MIPS word width.
REQ-002 SHALL have parameter DATA_BITS, default 8, UART byte width; NBITS is an exact multiple of DATA_BITS.
REQ-003 SHALL have parameter CELDAS_REGISTROS, default 32, number of register-file entries dumped.
REQ-004 SHALL have parameter CELDAS_MEM_DATOS, default 16, number of data-memory words dumped.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous, active-low reset.
REQ-007 SHALL have port i_start, input, 1 bit, one-cycle dump request.
REQ-008 SHALL have port i_mips_pc, input, NBITS bits, current PC.
REQ-009 SHALL have port i_mips_clk_count, input, NBITS bits, MIPS cycle count.
REQ-010 SHALL have port i_mips_reg, input, NBITS bits, register value selected by o_mips_reg.
REQ-011 SHALL have port i_mips_mem, input, NBITS bits, memory word selected by o_mips_mem.
REQ-012 SHALL have port i_uart_tx_done, input, 1 bit, one-cycle pulse when the transmitter finishes a byte.
REQ-013 SHALL have port o_mips_reg, output, clog2(CELDAS_REGISTROS) bits, register select.
REQ-014 SHALL have port o_mips_mem, output, NBITS bits, memory word select.
REQ-015 SHALL have port o_uart_tx_data, output, DATA_BITS bits, byte to send.
REQ-016 SHALL have port o_uart_tx_ready, output, 1 bit, one-cycle transmit-start pulse.
REQ-017 SHALL have port o_busy, output, 1 bit, high while a dump is in progress.
REQ-018 SHALL have port o_done, output, 1 bit, one-cycle pulse when a dump completes.

Function
REQ-019 SHALL dump words in this order: PC, clock count, registers 0..CELDAS_REGISTROS-1, then memory words 0..CELDAS_MEM_DATOS-1; default total is 50 words (200 bytes).
REQ-020 SHALL send each word as NBITS/DATA_BITS bytes, least-significant byte first.
REQ-021 SHALL implement states IDLE, SELECT, LOAD, SEND, WAIT, NEXT and DONE.
REQ-022 In IDLE, i_start=1 SHALL move the FSM to SELECT and clear the word index; i_start SHALL be ignored in every other state.
REQ-023 SELECT SHALL drive o_mips_reg or o_mips_mem for the current word for one cycle, then move to LOAD.
REQ-024 LOAD SHALL capture the selected word into a shift register, clear the byte index and move to SEND.
REQ-025 SEND SHALL assert o_uart_tx_ready for exactly one cycle with o_uart_tx_data equal to the shift register's low byte, then move to WAIT.
REQ-026 o_uart_tx_data SHALL stay stable from SEND until i_uart_tx_done is sampled in WAIT.
REQ-027 i_uart_tx_done SHALL be counted only in WAIT; a pulse arriving in any other state SHALL be ignored.
REQ-028 In WAIT, on i_uart_tx_done: if the byte index is below the last byte, the shift register SHALL shift right by DATA_BITS, the byte index SHALL increment, and the FSM SHALL return to SEND; otherwise it SHALL go to NEXT.
REQ-029 NEXT SHALL increment the word index, then go to DONE if the last word was just sent, else to SELECT.
REQ-030 DONE SHALL pulse o_done for one cycle, then return to IDLE.
REQ-031 o_busy SHALL be 1 in every state except IDLE.
REQ-032 The minimum latency from i_start to the first o_uart_tx_ready SHALL be 3 cycles (SELECT, LOAD, SEND).
REQ-033 WAIT SHALL have no timeout; the block waits indefinitely for i_uart_tx_done.

Reset
REQ-034 While reset=0 at a clock edge, the FSM SHALL go to IDLE, and every output, the word/byte indices and the shift register SHALL be 0.
REQ-035 Reset asserted in any state, including mid-byte, SHALL abort the dump with no o_done pulse; the next i_start SHALL restart from the PC.

Configuration
REQ-036 The macro DUMP_MEM_EN SHALL control whether data memory is dumped.
- Defined: memory words are included, giving 50 words / 200 bytes at default parameters.
- Undefined: the dump ends after the last register, giving 34 words / 136 bytes; o_mips_mem is held at 0 and i_mips_mem is unused.

Verification
REQ-037 Scenario, full dump: PC=0x12345678, tx_done returned 2 cycles after each o_uart_tx_ready -> first bytes 0x78,0x56,0x34,0x12; 200 ready pulses; one o_done.
REQ-038 Scenario, register dump: register n reads as 0xA0000000+n -> o_mips_reg steps 0..31; bytes 8..11 are 0x00,0x00,0x00,0xA0; the last register's high byte is 0xA0.
REQ-039 Scenario, start while busy: i_start pulsed during WAIT -> no restart; byte count stays 200; exactly one o_done.
REQ-040 Scenario, reset mid-dump: reset=0 during WAIT of byte 5 -> next cycle o_busy=0 and all outputs 0; a new i_start sends the PC low byte first.
REQ-041 Scenario, early done: i_uart_tx_done=1 in the SEND cycle -> ignored; no byte skipped; 200 bytes total.
REQ-042 Scenario, macro off: DUMP_MEM_EN undefined -> 136 bytes sent; o_mips_mem stays 0 throughout.
